// File: rtl/pc_src_ctrl_if.sv
// PC source controller bus: decode inputs, ALU flags, exception requests,
// retired-counter preload, and the PC/IR/EPC write controls back to the datapath.
interface pc_src_ctrl_if;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic        zero;
    logic        gt;
    logic        instr_done;
    logic        overflow;
    logic        div_zero;
    logic        retired_load;
    logic [31:0] retired_load_val;
    logic [2:0]  PcSrc;
    logic        PCWrite;
    logic        IRWrite;
    logic        epc_write;
    logic        link_write;
    logic [7:0]  exc_vec;
    logic [1:0]  exc_cause;
    logic [31:0] retired;

    // Controller side
    modport master (
        input  opcode, funct, zero, gt, instr_done, overflow, div_zero,
        input  retired_load, retired_load_val,
        output PcSrc, PCWrite, IRWrite, epc_write, link_write,
        output exc_vec, exc_cause, retired
    );

    // Datapath side
    modport slave (
        output opcode, funct, zero, gt, instr_done, overflow, div_zero,
        output retired_load, retired_load_val,
        input  PcSrc, PCWrite, IRWrite, epc_write, link_write,
        input  exc_vec, exc_cause, retired
    );
endinterface

// File: rtl/pc_src_ctrl.sv
// PC source controller: fetch/decode sequencing, branch/jump/jr PC selection,
// exception entry through a vectored handler, and a retired-instruction counter.
// Strobes are decoded from state only; PCWrite in BRANCH also looks at the flags.
module pc_src_ctrl (
    input  logic              clk,
    input  logic              reset,
    pc_src_ctrl_if.master     bus
);

    typedef enum logic [3:0] {
        FETCH1 = 4'd0,
        FETCH2 = 4'd1,
        FETCH3 = 4'd2,
        DECODE = 4'd3,
        BRANCH = 4'd4,
        JUMP   = 4'd5,
        JR     = 4'd6,
        EXEC   = 4'd7,
        EXC1   = 4'd8,
        EXC2   = 4'd9,
        EXC3   = 4'd10
    } state_t;

    localparam logic [1:0] CAUSE_INVALID  = 2'b00;
    localparam logic [1:0] CAUSE_OVERFLOW = 2'b01;
    localparam logic [1:0] CAUSE_DIVZERO  = 2'b10;

    state_t      state_q, state_d;
    logic [5:0]  opcode_q, opcode_d;
    logic [1:0]  exc_cause_q, exc_cause_d;
    logic [7:0]  exc_vec_q, exc_vec_d;
    logic [31:0] retired_q, retired_d;
    logic        exc_take_s;
    logic [1:0]  exc_code_s;

    // Handler vector address in memory for each exception cause
    function automatic logic [7:0] cause_to_vec(input logic [1:0] cause);
        logic [7:0] vec;
        case (cause)
            2'b00:   vec = 8'd253;
            2'b01:   vec = 8'd254;
            2'b10:   vec = 8'd255;
            default: vec = 8'd255;
        endcase
        return vec;
    endfunction

    // Next-state, opcode capture, exception latch and retired counter update
    always_comb begin
        state_d     = state_q;
        opcode_d    = opcode_q;
        exc_cause_d = exc_cause_q;
        exc_vec_d   = exc_vec_q;
        retired_d   = retired_q;
        exc_take_s  = 1'b0;
        exc_code_s  = CAUSE_INVALID;

        case (state_q)
            FETCH1: state_d = FETCH2;
            FETCH2: state_d = FETCH3;
            FETCH3: state_d = DECODE;
            DECODE: begin
                opcode_d = bus.opcode;
                case (bus.opcode)
                    6'h04, 6'h05, 6'h06, 6'h07: state_d = BRANCH;
                    6'h02, 6'h03:               state_d = JUMP;
                    6'h00: begin
                        if (bus.funct == 6'h08) begin
                            state_d = JR;
                        end else begin
                            state_d = EXEC;
                        end
                    end
                    6'h08, 6'h0F, 6'h23, 6'h2B, 6'h20, 6'h28: state_d = EXEC;
                    default: begin
                        exc_take_s = 1'b1;
                        exc_code_s = CAUSE_INVALID;
                    end
                endcase
            end
            BRANCH, JUMP, JR: begin
                state_d   = FETCH1;
                retired_d = retired_q + 32'd1;
            end
            EXEC: begin
                // Exceptions beat completion; overflow beats divide-by-zero
                if (bus.overflow) begin
                    exc_take_s = 1'b1;
                    exc_code_s = CAUSE_OVERFLOW;
                end else if (bus.div_zero) begin
                    exc_take_s = 1'b1;
                    exc_code_s = CAUSE_DIVZERO;
                end else if (bus.instr_done) begin
                    state_d   = FETCH1;
                    retired_d = retired_q + 32'd1;
                end else begin
                    state_d = EXEC;
                end
            end
            EXC1:    state_d = EXC2;
            EXC2:    state_d = EXC3;
            EXC3:    state_d = FETCH1;
            default: state_d = FETCH1;
        endcase

        // Cause and vector are captured on entry so they are visible during EXC1
        if (exc_take_s) begin
            state_d     = EXC1;
            exc_cause_d = exc_code_s;
            exc_vec_d   = cause_to_vec(exc_code_s);
        end else begin
            exc_cause_d = exc_cause_d;
        end

        if (bus.retired_load) begin
            retired_d = bus.retired_load_val;
        end else begin
            retired_d = retired_d;
        end
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= FETCH1;
            opcode_q    <= 6'd0;
            exc_cause_q <= 2'b00;
            exc_vec_q   <= 8'd0;
            retired_q   <= 32'd0;
        end else begin
            state_q     <= state_d;
            opcode_q    <= opcode_d;
            exc_cause_q <= exc_cause_d;
            exc_vec_q   <= exc_vec_d;
            retired_q   <= retired_d;
        end
    end

    // Strobe and PC mux decode from the current state
    always_comb begin
        bus.PcSrc      = 3'b000;
        bus.PCWrite    = 1'b0;
        bus.IRWrite    = 1'b0;
        bus.epc_write  = 1'b0;
        bus.link_write = 1'b0;
        case (state_q)
            FETCH3: begin
                bus.IRWrite = 1'b1;
                bus.PCWrite = 1'b1;
            end
            BRANCH: begin
                bus.PcSrc = 3'b001;
                case (opcode_q)
                    6'h04:   bus.PCWrite = bus.zero;
                    6'h05:   bus.PCWrite = ~bus.zero;
                    6'h06:   bus.PCWrite = ~bus.gt;
                    6'h07:   bus.PCWrite = bus.gt;
                    default: bus.PCWrite = 1'b0;
                endcase
            end
            JUMP: begin
                bus.PcSrc      = 3'b010;
                bus.PCWrite    = 1'b1;
                bus.link_write = (opcode_q == 6'h03);
            end
            JR: begin
                bus.PcSrc   = 3'b011;
                bus.PCWrite = 1'b1;
            end
            EXC1: bus.epc_write = 1'b1;
            EXC3: begin
                bus.PcSrc   = 3'b100;
                bus.PCWrite = 1'b1;
            end
            default: bus.PcSrc = 3'b000;
        endcase
    end

    assign bus.exc_cause = exc_cause_q;
    assign bus.exc_vec   = exc_vec_q;
    assign bus.retired   = retired_q;

endmodule

// File: tb/tb_pc_src_ctrl.sv
// Directed testbench for pc_src_ctrl with hand-computed expected values.
module tb_pc_src_ctrl;

    logic clk;
    logic reset;
    int   vec_cnt;
    int   err_cnt;

    pc_src_ctrl_if bus_if ();

    pc_src_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Output strobes packed as {PcSrc[2:0], PCWrite, IRWrite, epc_write, link_write}
    function automatic logic [6:0] outs();
        return {bus_if.PcSrc, bus_if.PCWrite, bus_if.IRWrite, bus_if.epc_write, bus_if.link_write};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // From FETCH1: walk through fetch, present the instruction, land in DECODE
    task automatic run_fetch(input logic [5:0] op, input logic [5:0] fn);
        step();
        chk("fetch2_outs", {25'd0, outs()}, 32'h00);
        step();
        chk("fetch3_outs", {25'd0, outs()}, {25'd0, 7'b000_1100});
        bus_if.opcode = op;
        bus_if.funct  = fn;
        step();
        chk("decode_outs", {25'd0, outs()}, 32'h00);
    endtask

    // Walk EXC1..EXC3 and back to FETCH1, checking the exception outputs
    task automatic run_exc(input logic [1:0] cause, input logic [7:0] vec, input logic [31:0] ret);
        step();
        chk("exc1_outs", {25'd0, outs()}, {25'd0, 7'b000_0010});
        chk("exc1_cause", {30'd0, bus_if.exc_cause}, {30'd0, cause});
        chk("exc1_vec", {24'd0, bus_if.exc_vec}, {24'd0, vec});
        bus_if.overflow   = 1'b0;
        bus_if.div_zero   = 1'b0;
        bus_if.instr_done = 1'b0;
        step();
        chk("exc2_outs", {25'd0, outs()}, 32'h00);
        step();
        chk("exc3_outs", {25'd0, outs()}, {25'd0, 7'b100_1000});
        step();
        chk("exc_retired", bus_if.retired, ret);
        chk("exc_cause_hold", {30'd0, bus_if.exc_cause}, {30'd0, cause});
    endtask

    logic [5:0] br_op  [6];
    logic       br_z   [6];
    logic       br_g   [6];
    logic       br_pcw [6];

    initial begin
        vec_cnt = 0;
        err_cnt = 0;
        reset = 1'b1;
        bus_if.opcode = 6'd0;
        bus_if.funct = 6'd0;
        bus_if.zero = 1'b0;
        bus_if.gt = 1'b0;
        bus_if.instr_done = 1'b0;
        bus_if.overflow = 1'b0;
        bus_if.div_zero = 1'b0;
        bus_if.retired_load = 1'b0;
        bus_if.retired_load_val = 32'd0;
        br_op  = '{6'h04, 6'h04, 6'h05, 6'h07, 6'h06, 6'h06};
        br_z   = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        br_g   = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        br_pcw = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

        step();
        step();
        chk("rst_outs", {25'd0, outs()}, 32'h00);
        chk("rst_cause", {30'd0, bus_if.exc_cause}, 32'h0);
        chk("rst_vec", {24'd0, bus_if.exc_vec}, 32'h0);
        chk("rst_retired", bus_if.retired, 32'h0);
        reset = 1'b0;

        // j: FETCH3 strobes, then JUMP with no link
        run_fetch(6'h02, 6'h00);
        step();
        chk("j_outs", {25'd0, outs()}, {25'd0, 7'b010_1000});
        step();
        chk("j_retired", bus_if.retired, 32'd1);

        // Branch conditions: beq/bne/bgt/ble
        for (int i = 0; i < 6; i++) begin
            run_fetch(br_op[i], 6'h00);
            bus_if.zero = br_z[i];
            bus_if.gt   = br_g[i];
            step();
            chk("br_outs", {25'd0, outs()}, {25'd0, 3'b001, br_pcw[i], 3'b000});
            step();
            chk("br_retired", bus_if.retired, 32'd2 + 32'(i));
            bus_if.zero = 1'b0;
            bus_if.gt   = 1'b0;
        end

        // jal links
        run_fetch(6'h03, 6'h00);
        step();
        chk("jal_outs", {25'd0, outs()}, {25'd0, 7'b010_1001});
        step();
        chk("jal_retired", bus_if.retired, 32'd8);

        // Invalid opcode
        run_fetch(6'h3F, 6'h00);
        run_exc(2'b00, 8'd253, 32'd8);

        // R-type add: holds, then all three events together -> overflow
        run_fetch(6'h00, 6'h20);
        step();
        chk("exec_outs", {25'd0, outs()}, 32'h00);
        step();
        chk("exec_hold_outs", {25'd0, outs()}, 32'h00);
        bus_if.instr_done = 1'b1;
        bus_if.overflow   = 1'b1;
        bus_if.div_zero   = 1'b1;
        run_exc(2'b01, 8'd254, 32'd8);

        // lw with div_zero and instr_done together -> divide-by-zero
        run_fetch(6'h23, 6'h00);
        step();
        bus_if.instr_done = 1'b1;
        bus_if.div_zero   = 1'b1;
        run_exc(2'b10, 8'd255, 32'd8);

        // sw completes normally
        run_fetch(6'h2B, 6'h00);
        step();
        bus_if.instr_done = 1'b1;
        step();
        bus_if.instr_done = 1'b0;
        chk("sw_retired", bus_if.retired, 32'd9);
        chk("sw_cause_hold", {30'd0, bus_if.exc_cause}, 32'h2);

        // Reset in EXC2
        run_fetch(6'h3F, 6'h00);
        step();
        step();
        chk("exc2_before_rst", {25'd0, outs()}, 32'h00);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("rst2_outs", {25'd0, outs()}, 32'h00);
        chk("rst2_cause", {30'd0, bus_if.exc_cause}, 32'h0);
        chk("rst2_vec", {24'd0, bus_if.exc_vec}, 32'h0);
        chk("rst2_retired", bus_if.retired, 32'h0);

        // Preload to all-ones then retire a jr: counter wraps
        bus_if.retired_load     = 1'b1;
        bus_if.retired_load_val = 32'hFFFF_FFFF;
        step();
        bus_if.retired_load = 1'b0;
        chk("preload", bus_if.retired, 32'hFFFF_FFFF);
        step();
        chk("jr_fetch3", {25'd0, outs()}, {25'd0, 7'b000_1100});
        bus_if.opcode = 6'h00;
        bus_if.funct  = 6'h08;
        step();
        step();
        chk("jr_outs", {25'd0, outs()}, {25'd0, 7'b011_1000});
        step();
        chk("jr_wrap", bus_if.retired, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
